vend_controller: RTL
====================

Name: vend_controller

Overview:
Multi-product vending controller that sits between the coin acceptor, the selection keypad and the mechanical dispenser. It accumulates credit from coin pulses, validates a product selection against price and stock, and runs a req/ack handshake with the dispenser. It then returns change one unit per cycle. It is the sequencing and arbitration layer above the single-product vending FSM and owns per-product stock counts.

Parameters:
NUM_PROD, 4, number of products (sel_id/disp_id width = clog2(NUM_PROD)).
CREDIT_W, 5, credit register width; maximum credit is 2^CREDIT_W-1.
STOCK_W, 4, per-product stock counter width.
INIT_STOCK, 5, stock loaded per product at reset and on refill.
PRICE_VEC, 16'h5432, packed 4-bit prices, product i at bits [4i+3:4i]; default prices are p0=2, p1=3, p2=4, p3=5.
TIMEOUT, 16, maximum cycles in DISPENSE waiting for disp_ack.

Ports:
clock  in  1  single clock; all logic on posedge.
rst  in  1  synchronous reset, active-low; sampled on posedge clock.
coin  in  2  coin code, sampled every cycle: 0 none, 1 = 1 unit, 2 = 2 units, 3 invalid.
sel_valid  in  1  selection strobe, one cycle.
sel_id  in  2  product index, valid with sel_valid.
cancel  in  1  refund request, one cycle.
refill  in  1  reload all stock counters to INIT_STOCK.
disp_ack  in  1  dispenser done.
disp_req  out  1  dispense request, held until ack or timeout.
disp_id  out  2  product being dispensed; stable while disp_req=1.
change_coin  out  1  one-cycle pulse per unit of change returned.
coin_reject  out  1  one-cycle pulse; coin not credited.
sel_err  out  1  one-cycle pulse; selection refused.
credit  out  CREDIT_W  current credit.
sold_out  out  NUM_PROD  bit i = 1 when stock[i]==0.
busy  out  1  1 in any state other than IDLE.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE; credit=0; all stock=INIT_STOCK; disp_req, disp_id, change_coin, coin_reject, sel_err and busy all 0; sold_out=0; timeout counter=0. Reset mid-DISPENSE or mid-CHANGE abandons the operation; the credit is lost.
- States: IDLE, DISPENSE, CHANGE. All outputs are registered.
- IDLE, coins:
  - coin 1 or 2: credit += value on the next edge.
  - coin 3: coin_reject pulse.
  - If credit+value would exceed 2^CREDIT_W-1: coin_reject pulse, credit unchanged (no saturation or partial credit).
- IDLE, priority cancel > sel_valid > refill:
  - cancel with credit>0: go to CHANGE. cancel with credit==0: no effect.
  - sel_valid: compared against the registered credit, before any same-cycle coin.
    - credit>=price[sel_id] and stock>0: go to DISPENSE; credit -= price; disp_id=sel_id; disp_req=1 on the next cycle.
    - otherwise: sel_err pulse, stay in IDLE.
  - A coin in the same cycle as sel_valid or cancel is still credited (post-decrement) if it fits.
  - refill: all stock=INIT_STOCK. refill outside IDLE is ignored.
- Coins outside IDLE: coin_reject pulse, not credited.
- DISPENSE:
  - disp_req=1 and the timeout counter increments.
  - disp_ack: stock[disp_id] -= 1; disp_req=0 on the next edge; go to CHANGE if credit>0, else IDLE.
  - No ack after TIMEOUT cycles: disp_req=0; credit += price (full refund); go to CHANGE.
  - An ack on the same cycle as the timeout expiry wins.
- CHANGE: change_coin=1 and credit -= 1 every cycle; leave to IDLE on the edge where credit becomes 0. CHANGE lasts exactly the entry credit in cycles.
- sold_out is combinational from the stock counters. Stock never decrements below 0, because selection requires stock>0.

Test Plan:
1. Reset, coin=1 for three 1-cycle pulses (credit 3), sel_id=1 -> disp_req=1 with disp_id=1 and credit=0; disp_ack after 3 cycles -> stock[1]=4, IDLE, no change_coin pulse.
2. coin=2 twice (credit 4), sel_id=0 -> dispense; ack -> exactly 2 change_coin pulses on consecutive cycles, credit=0, busy=0.
3. credit=1, sel_id=3 (price 5) -> sel_err for one cycle, credit stays 1; cancel -> 1 change_coin pulse, credit=0.
4. Five successful buys of product 0 -> sold_out[0]=1; sixth select of product 0 -> sel_err; refill -> sold_out=0, stock[0]=5.
5. Buy product 2 with credit 4 and hold disp_ack=0 -> disp_req drops after 16 cycles, credit=4, then 4 change_coin pulses; a coin during DISPENSE -> coin_reject.
6. credit=30 then coin=2 -> coin_reject, credit=30; coin=3 -> coin_reject; rst=0 mid-CHANGE -> next cycle IDLE, credit=0, change_coin=0.

Source files
------------

// File: rtl/vend_if.sv
// Vending controller bus: coin acceptor, keypad and dispenser signals in one bundle.
interface vend_if #(
    parameter int unsigned NUM_PROD = 4,
    parameter int unsigned CREDIT_W = 5
);
    localparam int unsigned ID_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;

    logic [1:0]          coin;
    logic                sel_valid;
    logic [ID_W-1:0]     sel_id;
    logic                cancel;
    logic                refill;
    logic                disp_ack;
    logic                disp_req;
    logic [ID_W-1:0]     disp_id;
    logic                change_coin;
    logic                coin_reject;
    logic                sel_err;
    logic [CREDIT_W-1:0] credit;
    logic [NUM_PROD-1:0] sold_out;
    logic                busy;

    // Environment side: drives coins, keypad and dispenser ack.
    modport master (
        output coin, sel_valid, sel_id, cancel, refill, disp_ack,
        input  disp_req, disp_id, change_coin, coin_reject, sel_err, credit, sold_out, busy
    );

    // Controller side.
    modport slave (
        input  coin, sel_valid, sel_id, cancel, refill, disp_ack,
        output disp_req, disp_id, change_coin, coin_reject, sel_err, credit, sold_out, busy
    );
endinterface

// File: rtl/vend_controller.sv
// Multi-product vending controller: credit accumulation, selection checks,
// dispenser req/ack handshake with timeout refund, and unit-by-unit change.
module vend_controller #(
    parameter int unsigned              NUM_PROD   = 4,
    parameter int unsigned              CREDIT_W   = 5,
    parameter int unsigned              STOCK_W    = 4,
    parameter int unsigned              INIT_STOCK = 5,
    parameter logic [4*NUM_PROD-1:0]    PRICE_VEC  = 16'h5432,
    parameter int unsigned              TIMEOUT    = 16
) (
    input  logic  clock,
    input  logic  rst,
    vend_if.slave bus
);
    localparam int unsigned ID_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;
    localparam int unsigned CW1  = CREDIT_W + 1;
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DISPENSE, S_CHANGE} state_e;

    state_e              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [STOCK_W-1:0]  stock_q [NUM_PROD];
    logic [TO_W-1:0]     tmo_q;
    logic                disp_req_q;
    logic [ID_W-1:0]     disp_id_q;
    logic                change_q;
    logic                reject_q;
    logic                sel_err_q;
    logic                busy_q;

    logic [CW1-1:0]      coin_val;
    logic                coin_bad;
    logic [CREDIT_W-1:0] sel_price;
    logic [CREDIT_W-1:0] disp_price;
    logic                sel_ok;
    logic [CREDIT_W-1:0] base_credit;
    logic [CW1-1:0]      coin_sum;
    logic                coin_fits;
    logic [CREDIT_W-1:0] idle_credit;
    logic [CW1-1:0]      refund_sum;
    logic [CREDIT_W-1:0] refund_credit;
    logic [NUM_PROD-1:0] sold_out_c;

    // Coin decode, selection check and the candidate credit values for this cycle.
    always_comb begin
        coin_val = '0;
        coin_bad = 1'b0;
        case (bus.coin)
            2'd1:    coin_val = CW1'(1);
            2'd2:    coin_val = CW1'(2);
            2'd3:    coin_bad = 1'b1;
            default: coin_val = '0;
        endcase
        sel_price   = CREDIT_W'(PRICE_VEC[{bus.sel_id, 2'b00} +: 4]);
        disp_price  = CREDIT_W'(PRICE_VEC[{disp_id_q, 2'b00} +: 4]);
        // Selection is judged on registered credit; cancel masks it.
        sel_ok      = bus.sel_valid && !bus.cancel && (credit_q >= sel_price)
                      && (stock_q[bus.sel_id] != '0);
        base_credit = sel_ok ? (credit_q - sel_price) : credit_q;
        coin_sum    = {1'b0, base_credit} + coin_val;
        coin_fits   = !coin_sum[CREDIT_W];
        idle_credit = ((coin_val != '0) && coin_fits) ? coin_sum[CREDIT_W-1:0] : base_credit;
        // A refund can only overflow if a same-cycle coin topped credit up; clamp it.
        refund_sum    = {1'b0, credit_q} + {1'b0, disp_price};
        refund_credit = refund_sum[CREDIT_W] ? '1 : refund_sum[CREDIT_W-1:0];
    end

    // Controller FSM with registered outputs and per-product stock.
    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            credit_q   <= '0;
            tmo_q      <= '0;
            disp_req_q <= 1'b0;
            disp_id_q  <= '0;
            change_q   <= 1'b0;
            reject_q   <= 1'b0;
            sel_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            for (int i = 0; i < NUM_PROD; i++) begin
                stock_q[i] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            reject_q  <= 1'b0;
            sel_err_q <= 1'b0;
            change_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    credit_q <= idle_credit;
                    reject_q <= coin_bad || ((coin_val != '0) && !coin_fits);
                    if (bus.cancel) begin
                        if (credit_q != '0) begin
                            state_q  <= S_CHANGE;
                            change_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end
                    end else if (bus.sel_valid) begin
                        if (sel_ok) begin
                            state_q    <= S_DISPENSE;
                            disp_req_q <= 1'b1;
                            disp_id_q  <= bus.sel_id;
                            tmo_q      <= '0;
                            busy_q     <= 1'b1;
                        end else begin
                            sel_err_q <= 1'b1;
                        end
                    end else if (bus.refill) begin
                        for (int i = 0; i < NUM_PROD; i++) begin
                            stock_q[i] <= STOCK_W'(INIT_STOCK);
                        end
                    end
                end
                S_DISPENSE: begin
                    reject_q <= (bus.coin != 2'd0);
                    if (bus.disp_ack) begin
                        stock_q[disp_id_q] <= stock_q[disp_id_q] - STOCK_W'(1);
                        disp_req_q <= 1'b0;
                        if (credit_q != '0) begin
                            state_q  <= S_CHANGE;
                            change_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (tmo_q == TO_W'(TIMEOUT - 1)) begin
                        disp_req_q <= 1'b0;
                        credit_q   <= refund_credit;
                        state_q    <= S_CHANGE;
                        change_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TO_W'(1);
                    end
                end
                S_CHANGE: begin
                    reject_q <= (bus.coin != 2'd0);
                    credit_q <= credit_q - CREDIT_W'(1);
                    if (credit_q == CREDIT_W'(1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        change_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Sold-out flags decoded straight from the stock registers.
    always_comb begin
        for (int i = 0; i < NUM_PROD; i++) begin
            sold_out_c[i] = (stock_q[i] == '0);
        end
    end

    assign bus.disp_req    = disp_req_q;
    assign bus.disp_id     = disp_id_q;
    assign bus.change_coin = change_q;
    assign bus.coin_reject = reject_q;
    assign bus.sel_err     = sel_err_q;
    assign bus.credit      = credit_q;
    assign bus.sold_out    = sold_out_c;
    assign bus.busy        = busy_q;
endmodule
